// File: rtl/instr_fetch_buffer.sv
// In-order instruction fetch buffer: issues word reads for incoming PCs and hands the returned
// instructions to decode. Optional FETCH_BYPASS_EN forwards a response straight to an empty head.
module instr_fetch_buffer #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] pc_in_i,
  input  logic             pc_valid_i,
  output logic             pc_ready_o,
  input  logic             redirect_i,
  output logic             mem_req_valid_o,
  output logic [WIDTH-1:0] mem_req_addr_o,
  input  logic             mem_req_ready_i,
  input  logic             mem_rsp_valid_i,
  input  logic [WIDTH-1:0] mem_rsp_data_i,
  output logic             instr_valid_o,
  output logic [WIDTH-1:0] instr_o,
  output logic [WIDTH-1:0] instr_pc_o,
  input  logic             instr_ready_i
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  typedef logic [PtrW-1:0] ptr_t;
  typedef logic [CntW-1:0] cnt_t;
  typedef enum logic [0:0] {StRun, StDrain} state_e;

  logic [WIDTH-1:0] pc_q   [DEPTH];
  logic [WIDTH-1:0] data_q [DEPTH];
  logic [DEPTH-1:0] filled_q;
  ptr_t             alloc_ptr_q, alloc_ptr_d;
  ptr_t             fill_ptr_q, fill_ptr_d;
  ptr_t             head_ptr_q, head_ptr_d;
  // pend counts allocated entries still waiting for their response
  cnt_t             occ_q, occ_d, pend_q, pend_d, kill_q, kill_d;
  state_e           state_q, state_d;

  logic credit, alloc, fill, pop, bypass, head_filled, rsp_due;

  assign credit          = (occ_q + kill_q) < cnt_t'(DEPTH);
  assign mem_req_valid_o = rst_ni & pc_valid_i & credit & ~redirect_i;
  assign pc_ready_o      = mem_req_valid_o & mem_req_ready_i;
  assign mem_req_addr_o  = {pc_in_i[WIDTH-1:2], 2'b00};

  assign alloc       = pc_ready_o;
  assign fill        = rst_ni & mem_rsp_valid_i & ~redirect_i & (state_q == StRun) &
                       (pend_q != '0);
  assign head_filled = filled_q[head_ptr_q];
  assign rsp_due     = (kill_q != '0) | (pend_q != '0);

`ifdef FETCH_BYPASS_EN
  // Entries fill in order, so an unfilled head is exactly the entry at fill_ptr.
  assign bypass = fill & ~head_filled & (fill_ptr_q == head_ptr_q);
`else
  assign bypass = 1'b0;
`endif

  assign instr_valid_o = ~redirect_i & (head_filled | bypass);
  assign instr_o       = bypass ? mem_rsp_data_i : data_q[head_ptr_q];
  assign instr_pc_o    = pc_q[head_ptr_q];
  assign pop           = instr_valid_o & instr_ready_i;

  always_comb begin
    alloc_ptr_d = alloc_ptr_q;
    fill_ptr_d  = fill_ptr_q;
    head_ptr_d  = head_ptr_q;
    occ_d       = occ_q;
    pend_d      = pend_q;
    kill_d      = kill_q;
    if (redirect_i) begin
      fill_ptr_d = alloc_ptr_q;
      head_ptr_d = alloc_ptr_q;
      occ_d      = '0;
      pend_d     = '0;
      kill_d     = kill_q + pend_q - cnt_t'(mem_rsp_valid_i & rsp_due);
    end else begin
      if (alloc) alloc_ptr_d = alloc_ptr_q + ptr_t'(1);
      if (fill) fill_ptr_d = fill_ptr_q + ptr_t'(1);
      if (pop) head_ptr_d = head_ptr_q + ptr_t'(1);
      if (mem_rsp_valid_i && state_q == StDrain) kill_d = kill_q - cnt_t'(1);
      occ_d  = occ_q + cnt_t'(alloc) - cnt_t'(pop);
      pend_d = pend_q + cnt_t'(alloc) - cnt_t'(fill);
    end
    state_d = (kill_d != '0) ? StDrain : StRun;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        pc_q[i]   <= '0;
        data_q[i] <= '0;
      end
      filled_q    <= '0;
      alloc_ptr_q <= '0;
      fill_ptr_q  <= '0;
      head_ptr_q  <= '0;
      occ_q       <= '0;
      pend_q      <= '0;
      kill_q      <= '0;
      state_q     <= StRun;
    end else begin
      alloc_ptr_q <= alloc_ptr_d;
      fill_ptr_q  <= fill_ptr_d;
      head_ptr_q  <= head_ptr_d;
      occ_q       <= occ_d;
      pend_q      <= pend_d;
      kill_q      <= kill_d;
      state_q     <= state_d;
      if (redirect_i) begin
        filled_q <= '0;
      end else begin
        if (alloc) begin
          pc_q[alloc_ptr_q]     <= pc_in_i;
          filled_q[alloc_ptr_q] <= 1'b0;
        end
        if (fill) begin
          data_q[fill_ptr_q]   <= mem_rsp_data_i;
          filled_q[fill_ptr_q] <= 1'b1;
        end
        // Clearing on pop keeps a freed head from looking valid; also wins for a bypassed pop.
        if (pop) filled_q[head_ptr_q] <= 1'b0;
      end
    end
  end

  rsp_expected_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
    mem_rsp_valid_i |-> rsp_due);

endmodule

// File: tb/tb_instr_fetch_buffer.sv
// Bench for instr_fetch_buffer: queue-based reference model checked every cycle, an in-order
// memory responder with adjustable latency, and directed scenarios with literal expectations.
module tb_instr_fetch_buffer;
  localparam int unsigned W = 32;
  localparam int unsigned D = 4;
`ifdef FETCH_BYPASS_EN
  localparam bit Byp = 1'b1;
`else
  localparam bit Byp = 1'b0;
`endif
  localparam int LatD = Byp ? 1 : 2;

  logic         clk, rst_n;
  logic [W-1:0] pc_in, mem_req_addr, mem_rsp_data, instr, instr_pc;
  logic         pc_valid, pc_ready, redirect, mem_req_valid, mem_req_ready, mem_rsp_valid;
  logic         instr_valid, instr_ready;

  instr_fetch_buffer #(.WIDTH(W), .DEPTH(D)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .pc_in_i        (pc_in),
    .pc_valid_i     (pc_valid),
    .pc_ready_o     (pc_ready),
    .redirect_i     (redirect),
    .mem_req_valid_o(mem_req_valid),
    .mem_req_addr_o (mem_req_addr),
    .mem_req_ready_i(mem_req_ready),
    .mem_rsp_valid_i(mem_rsp_valid),
    .mem_rsp_data_i (mem_rsp_data),
    .instr_valid_o  (instr_valid),
    .instr_o        (instr),
    .instr_pc_o     (instr_pc),
    .instr_ready_i  (instr_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'd3) ^ 32'h1357_9BDF;
  endfunction

  // Memory responder: in order, response no earlier than lat cycles after acceptance.
  typedef struct {logic [31:0] addr; int due;} req_t;
  req_t rq[$];
  int   cyc  = 0;
  int   lat  = 1;
  bit   hold = 1'b0;

  always @(posedge clk) begin
    cyc++;
    #1;
    if (rst_n && !hold && rq.size() > 0 && rq[0].due <= cyc) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = mem_word(rq[0].addr);
    end else begin
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = '0;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      rq.delete();
    end else begin
      if (mem_rsp_valid && rq.size() > 0) void'(rq.pop_front());
      if (mem_req_valid && mem_req_ready) rq.push_back('{addr: mem_req_addr, due: cyc + lat});
    end
  end

  // Reference model: queue of in-flight entries plus a count of responses to discard.
  typedef struct {logic [31:0] pc; logic [31:0] data; bit filled;} ent_t;
  ent_t mq[$];
  int   kill_m = 0;

  always @(negedge clk) begin
    bit ereq, epcr, eiv, fill_ok;
    int fi, unf;
    if (!rst_n) begin
      mq.delete();
      kill_m = 0;
      chk("rst_instr_valid", instr_valid, 0);
      chk("rst_mem_req_valid", mem_req_valid, 0);
      chk("rst_pc_ready", pc_ready, 0);
      chk("rst_instr", instr, 0);
      chk("rst_instr_pc", instr_pc, 0);
    end else begin
      ereq = pc_valid && (mq.size() + kill_m < D) && !redirect;
      epcr = ereq && mem_req_ready;
      fi = -1;
      foreach (mq[i]) if (!mq[i].filled && fi < 0) fi = i;
      fill_ok = mem_rsp_valid && kill_m == 0 && fi >= 0 && !redirect;
      eiv = !redirect && mq.size() > 0 && (mq[0].filled || (Byp && fill_ok && fi == 0));
      chk("mem_req_valid", mem_req_valid, ereq);
      chk("pc_ready", pc_ready, epcr);
      if (ereq) chk("mem_req_addr", mem_req_addr, {pc_in[31:2], 2'b00});
      chk("instr_valid", instr_valid, eiv);
      if (eiv) begin
        chk("instr_pc", instr_pc, mq[0].pc);
        chk("instr", instr, mq[0].filled ? mq[0].data : mem_rsp_data);
      end
      if (redirect) begin
        unf = 0;
        foreach (mq[i]) if (!mq[i].filled) unf++;
        kill_m = kill_m + unf - (mem_rsp_valid ? 1 : 0);
        if (kill_m < 0) kill_m = 0;
        mq.delete();
      end else begin
        if (mem_rsp_valid) begin
          if (kill_m > 0) kill_m--;
          else if (fi >= 0) begin
            mq[fi].filled = 1'b1;
            mq[fi].data   = mem_rsp_data;
          end
        end
        if (eiv && instr_ready) void'(mq.pop_front());
        if (epcr) mq.push_back('{pc: pc_in, data: 32'h0, filled: 1'b0});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_first(input string name, input logic [31:0] exp_pc);
    bit found = 1'b0;
    for (int n = 0; n < 20 && !found; n++) begin
      if (instr_valid) found = 1'b1;
      else tick();
    end
    chk({name, "_seen"}, {31'b0, found}, 1);
    chk(name, instr_pc, exp_pc);
  endtask

  task automatic feed(input logic [31:0] pc, input string name);
    pc_in    = pc;
    pc_valid = 1'b1;
    #1;
    chk(name, pc_ready, 1);
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; pc_valid = 1'b0; pc_in = '0; redirect = 1'b0;
    instr_ready = 1'b0; mem_req_ready = 1'b1; mem_rsp_valid = 1'b0; mem_rsp_data = '0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;

    // Straight-line fetch, latency 1, decode always ready
    instr_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      pc_in    = (i < 4) ? 32'(4 * i) : 32'h0;
      pc_valid = (i < 4);
      #1;
      if (i < 4) chk("straight_pc_ready", pc_ready, 1);
      if (i >= LatD && i - LatD < 4) begin
        chk("straight_valid", instr_valid, 1);
        chk("straight_instr_pc", instr_pc, 32'(4 * (i - LatD)));
      end
      tick();
    end
    pc_valid = 1'b0;
    repeat (3) tick();

    // Backpressure fills the buffer, then drains one per cycle
    instr_ready = 1'b0;
    for (int i = 0; i < 4; i++) feed(32'h40 + 32'(4 * i), "bp_accept");
    pc_in = 32'h50;
    #1;
    chk("full_pc_ready", pc_ready, 0);
    chk("full_req_valid", mem_req_valid, 0);
    repeat (3) tick();
    instr_ready = 1'b1;
    #1;
    chk("bp_pop_cycle_pc_ready", pc_ready, 0);
    chk("bp_pop0_pc", instr_pc, 32'h40);
    tick();
    #1;
    chk("bp_resume_pc_ready", pc_ready, 1);
    chk("bp_pop1_pc", instr_pc, 32'h44);
    tick();
    pc_valid = 1'b0;
    repeat (6) tick();

    // Redirect with two outstanding fetches
    hold = 1'b1;
    feed(32'h10, "redir_accept");
    feed(32'h14, "redir_accept");
    pc_valid = 1'b0;
    redirect = 1'b1;
    tick();
    redirect = 1'b0;
    feed(32'h100, "redir_new_accept");
    pc_valid = 1'b0;
    hold = 1'b0;
    wait_first("redir_first_pc", 32'h100);
    chk("redir_first_instr", instr, mem_word(32'h100));
    repeat (4) tick();

    // Response lands in the redirect cycle with three unfilled entries
    hold = 1'b1;
    feed(32'h20, "coinc_accept");
    feed(32'h24, "coinc_accept");
    feed(32'h28, "coinc_accept");
    pc_valid = 1'b0;
    hold = 1'b0;
    tick();
    redirect = 1'b1;
    tick();
    redirect = 1'b0;
    feed(32'h200, "coinc_new_accept");
    pc_valid = 1'b0;
    wait_first("coinc_first_pc", 32'h200);
    repeat (4) tick();

    // Async reset between edges with three filled entries
    instr_ready = 1'b0;
    feed(32'h30, "rst_accept");
    feed(32'h34, "rst_accept");
    feed(32'h38, "rst_accept");
    pc_valid = 1'b0;
    repeat (3) tick();
    chk("pre_rst_valid", instr_valid, 1);
    pc_in    = 32'h3C;
    pc_valid = 1'b1;
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", instr_valid, 0);
    chk("async_rst_pc_ready", pc_ready, 0);
    chk("async_rst_req_valid", mem_req_valid, 0);
    chk("async_rst_instr", instr, 0);
    chk("async_rst_instr_pc", instr_pc, 0);
    pc_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    instr_ready = 1'b1;
    feed(32'h0, "post_rst_accept");
    pc_valid = 1'b0;
    wait_first("post_rst_pc", 32'h0);
    chk("post_rst_instr", instr, mem_word(32'h0));
    repeat (3) tick();

    // Single fetch into an empty buffer: bypass timing
    feed(32'h60, "byp_accept");
    pc_valid = 1'b0;
    chk("byp_rsp_cycle_valid", instr_valid, Byp);
    chk("byp_rsp_cycle_instr", instr_valid ? instr : 32'h0, Byp ? mem_word(32'h60) : 32'h0);
    tick();
    chk("byp_next_cycle_valid", instr_valid, !Byp);
    chk("byp_next_cycle_instr", instr_valid ? instr : 32'h0, Byp ? 32'h0 : mem_word(32'h60));
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/instr_fetch_buffer.md
Name: instr_fetch_buffer

Overview:
- Consumer side of the program counter: takes PC values from the PC block and issues word reads to instruction memory.
- Holds each returned instruction with its PC in an in-order buffer and presents it to decode through a valid/ready handshake.
- The redirect input (branch/jump taken) flushes all buffered and in-flight fetches, so the next instruction delivered comes from the new PC.

Parameters:
- WIDTH, 32, address/instruction width.
- DEPTH, 4, buffer entries; power of two, at least 2.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- pc_in  in  WIDTH  PC to fetch.
- pc_valid  in  1  pc_in is valid.
- pc_ready  out  1  PC accepted this cycle; the PC block advances on pc_valid&&pc_ready.
- redirect  in  1  control transfer taken; flushes the buffer.
- mem_req_valid  out  1  memory read request.
- mem_req_addr  out  WIDTH  read address, word aligned.
- mem_req_ready  in  1  memory accepts the request.
- mem_rsp_valid  in  1  read data returned; responses arrive in order, at least 1 cycle after acceptance.
- mem_rsp_data  in  WIDTH  instruction word.
- instr_valid  out  1  instruction available to decode.
- instr  out  WIDTH  instruction word.
- instr_pc  out  WIDTH  PC of instr.
- instr_ready  in  1  decode consumes the instruction.

Behaviour:
- Storage: DEPTH entries of {pc, data, filled}, plus three pointers: alloc_ptr, fill_ptr, head_ptr (log2 DEPTH bits each, wrap modulo DEPTH).
  - occ = allocated entries (0..DEPTH).
  - kill = count of stale responses still due (0..DEPTH).
- Credit: credit = (occ + kill < DEPTH).
- Request path (combinational):
  - mem_req_valid = pc_valid && credit && !redirect && rst.
  - pc_ready = mem_req_valid && mem_req_ready.
  - mem_req_addr = {pc_in[WIDTH-1:2], 2'b00}.
- Allocate: on pc_valid&&pc_ready, write pc_in at alloc_ptr, clear filled, alloc_ptr++, occ++.
- Fill: on mem_rsp_valid:
  - if kill>0, drop the data and kill--;
  - else write data at fill_ptr, set filled, fill_ptr++.
  - mem_rsp_valid with kill==0 and no unfilled entry is a protocol error: data ignored, simulation assertion fires.
- Output:
  - instr_valid = entry[head].filled; instr and instr_pc come from entry[head].
  - Pop on instr_valid&&instr_ready: head_ptr++, occ--.
- Latency: PC accepted at cycle N with memory response at cycle N+k gives instr_valid at cycle N+k+1.
- States:
  - RUN (kill==0) and DRAIN (kill>0).
  - RUN->DRAIN: redirect while unfilled entries exist.
  - DRAIN->RUN: when kill reaches 0.
  - New requests are allowed in DRAIN, subject to credit.
- Redirect cycle:
  - Priority over allocate and pop: instr_valid forced 0, no allocate, no pop.
  - All entries are invalidated; occ=0; all pointers are set equal to alloc_ptr.
  - kill_next = kill + unfilled − (1 if mem_rsp_valid this cycle).
  - A response arriving in the redirect cycle is dropped.
- Simultaneous fill and pop of different entries both happen. Simultaneous allocate and pop leave occ unchanged.
- Full: occ+kill==DEPTH gives pc_ready=0 and mem_req_valid=0. Empty: instr_valid=0.
- Reset (rst low, async, also mid-operation):
  - occ, kill, all pointers and filled flags go to 0.
  - instr_valid=0, mem_req_valid=0, pc_ready=0 immediately.
  - instr and instr_pc read 0.

Optional Feature:
- Macro FETCH_BYPASS_EN.
- Defined: when the head entry is unfilled and a non-killed response fills it this cycle, instr_valid=1 with instr=mem_rsp_data in the same cycle.
  - If instr_ready, the entry is filled and popped together.
  - Latency becomes N+k.
- Undefined: no combinational path from mem_rsp to instr; latency N+k+1.

Test Plan:
- Straight-line: PCs 0x0,0x4,0x8,0xC, memory latency 1, instr_ready=1 -> instr_pc 0x0..0xC in order, each instr_valid 2 cycles after PC acceptance, pc_ready continuously 1.
- Backpressure: instr_ready=0, DEPTH=4 -> after 4 accepted PCs pc_ready=0 and mem_req_valid=0; instr_ready=1 -> one pop per cycle, fetching resumes the following cycle.
- Redirect with 2 outstanding (0x10, 0x14 unfilled), pc_in=0x100 next -> kill=2, both stale responses dropped, first instr_pc delivered is 0x100.
- Response coincides with redirect (3 unfilled) -> that response is dropped, kill=2, next valid instr_pc equals the redirected PC.
- Async reset with 3 filled entries, asserted between clock edges -> instr_valid falls immediately; after release, a fetch of 0x0 is delivered normally.
- FETCH_BYPASS_EN defined, empty buffer, latency 1 -> instr_valid in the response cycle with instr equal to mem_rsp_data; undefined -> one cycle later.
